// File: rtl/write_pointer_ctrl.sv
// Write-side pointer and flag controller for an async FIFO: binary/Gray write
// pointer, read-pointer synchroniser, full/almost-full/free-count and overflow flags.
module write_pointer_ctrl #(
    parameter int ADDR_WIDTH   = 9,
    parameter int AFULL_THRESH = 4
) (
    input  logic                    wclk,
    input  logic                    wrst_n,
    input  logic                    winc,
    input  logic                    ovf_clr,
    input  logic [ADDR_WIDTH-1:0]   rptr_gray,
    output logic                    wen,
    output logic [ADDR_WIDTH-2:0]   waddr,
    output logic [ADDR_WIDTH-1:0]   wptr_gray,
    output logic                    wfull,
    output logic                    walmost_full,
    output logic [ADDR_WIDTH-1:0]   wfree,
    output logic                    woverflow
);

    localparam logic [ADDR_WIDTH-1:0] DEPTH     = {1'b1, {(ADDR_WIDTH-1){1'b0}}};
    localparam logic [ADDR_WIDTH-1:0] AFULL_LIM = ADDR_WIDTH'(AFULL_THRESH);

    logic [ADDR_WIDTH-1:0] r_wbin;
    logic [ADDR_WIDTH-1:0] r_wgray;
    logic [ADDR_WIDTH-1:0] r_rq1;
    logic [ADDR_WIDTH-1:0] r_rq2;
    logic                  r_wfull;
    logic                  r_walmost_full;
    logic [ADDR_WIDTH-1:0] r_wfree;
    logic                  r_woverflow;

    logic                  w_wen;
    logic [ADDR_WIDTH-1:0] w_wbin_next;
    logic [ADDR_WIDTH-1:0] w_wgray_next;
    logic [ADDR_WIDTH-1:0] w_rbin;
    logic [ADDR_WIDTH-1:0] w_used_next;
    logic [ADDR_WIDTH-1:0] w_wfree_next;
    logic                  w_wfull_next;

    // Reset gates the enable so a producer holding winc during reset never writes RAM.
    assign w_wen        = winc & ~r_wfull & wrst_n;
    assign w_wbin_next  = r_wbin + {{(ADDR_WIDTH-1){1'b0}}, w_wen};
    assign w_wgray_next = w_wbin_next ^ (w_wbin_next >> 1);

    // NOTE: every always_comb output gets a default before the loop so no latch is inferred.
    always_comb begin
        w_rbin = '0;
        for (int i = 0; i < ADDR_WIDTH; i++) begin
            w_rbin[i] = ^(r_rq2 >> i);
        end
    end

    assign w_used_next  = w_wbin_next - w_rbin;
    assign w_wfree_next = DEPTH - w_used_next;
    // Full when the pointers differ only in the two MSBs of the Gray code.
    assign w_wfull_next = (w_wgray_next == {~r_rq2[ADDR_WIDTH-1:ADDR_WIDTH-2],
                                             r_rq2[ADDR_WIDTH-3:0]});

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            r_wbin         <= '0;
            r_wgray        <= '0;
            r_rq1          <= '0;
            r_rq2          <= '0;
            r_wfull        <= 1'b0;
            r_walmost_full <= 1'b0;
            r_wfree        <= DEPTH;
            r_woverflow    <= 1'b0;
        end else begin
            r_wbin         <= w_wbin_next;
            r_wgray        <= w_wgray_next;
            r_rq1          <= rptr_gray;
            r_rq2          <= r_rq1;
            r_wfull        <= w_wfull_next;
            r_walmost_full <= (w_wfree_next <= AFULL_LIM);
            r_wfree        <= w_wfree_next;
            if (winc && r_wfull) begin
                r_woverflow <= 1'b1;
            end else if (ovf_clr) begin
                r_woverflow <= 1'b0;
            end
        end
    end

    assign wen          = w_wen;
    assign waddr        = r_wbin[ADDR_WIDTH-2:0];
    assign wptr_gray    = r_wgray;
    assign wfull        = r_wfull;
    assign walmost_full = r_walmost_full;
    assign wfree        = r_wfree;
    assign woverflow    = r_woverflow;

endmodule

// File: tb/tb_write_pointer_ctrl.sv
// Scoreboard bench for write_pointer_ctrl: a reference occupancy model pushes the
// expected post-edge state each cycle and the registered outputs are compared after the edge.
module tb_write_pointer_ctrl;

    localparam int AW = 9;

    logic          wclk = 1'b0;
    logic          wrst_n = 1'b0;
    logic          winc = 1'b0;
    logic          ovf_clr = 1'b0;
    logic [AW-1:0] rptr_gray = '0;
    logic          wen;
    logic [AW-2:0] waddr;
    logic [AW-1:0] wptr_gray;
    logic          wfull;
    logic          walmost_full;
    logic [AW-1:0] wfree;
    logic          woverflow;

    write_pointer_ctrl #(.ADDR_WIDTH(AW), .AFULL_THRESH(4)) dut (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .winc         (winc),
        .ovf_clr      (ovf_clr),
        .rptr_gray    (rptr_gray),
        .wen          (wen),
        .waddr        (waddr),
        .wptr_gray    (wptr_gray),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wfree        (wfree),
        .woverflow    (woverflow)
    );

    always #5 wclk = ~wclk;

    typedef struct packed {
        logic [AW-1:0] gray;
        logic [AW-1:0] free;
        logic          full;
        logic          afull;
        logic          ovf;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [AW-1:0] m_wbin = '0;
    logic [AW-1:0] m_rq1 = '0;
    logic [AW-1:0] m_rq2 = '0;
    logic          m_full = 1'b0;
    logic          m_ovf = 1'b0;
    int            m_writes = 0;
    logic [AW-1:0] rd_bin = '0;

    function automatic logic [AW-1:0] g2b(input logic [AW-1:0] g);
        logic [AW-1:0] b;
        b[AW-1] = g[AW-1];
        for (int i = AW-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic logic [AW-1:0] b2g(input logic [AW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // One clock: drive inputs, check combinational outputs, push the model's
    // expected post-edge state, then pop and compare after the edge.
    task automatic drive_cycle(input logic rst, input logic inc, input logic clr,
                               input logic [AW-1:0] rp);
        logic          exp_wen;
        logic [AW-1:0] nb;
        logic [AW-1:0] used;
        logic [AW-1:0] free;
        exp_t          e;
        exp_t          x;
        wrst_n = rst; winc = inc; ovf_clr = clr; rptr_gray = rp;
        #1;
        exp_wen = inc & ~m_full & rst;
        checks++;
        if (wen !== exp_wen) begin
            errors++;
            $display("FAIL wen: got %b expected %b at %0t", wen, exp_wen, $time);
        end
        if (exp_wen) begin
            checks++;
            if (waddr !== m_wbin[AW-2:0]) begin
                errors++;
                $display("FAIL waddr: got %0h expected %0h at %0t", waddr, m_wbin[AW-2:0], $time);
            end
        end
        if (!rst) begin
            e.gray = '0; e.free = 9'd256; e.full = 1'b0; e.afull = 1'b0; e.ovf = 1'b0;
            m_wbin = '0; m_rq1 = '0; m_rq2 = '0; m_full = 1'b0; m_ovf = 1'b0;
        end else begin
            nb = m_wbin + {8'd0, exp_wen};
            if (exp_wen) m_writes++;
            used = nb - g2b(m_rq2);
            free = 9'd256 - used;
            e.gray  = b2g(nb);
            e.free  = free;
            e.full  = (free == 9'd0);
            e.afull = (free <= 9'd4);
            e.ovf   = (inc && m_full) ? 1'b1 : (clr ? 1'b0 : m_ovf);
            m_wbin = nb; m_rq2 = m_rq1; m_rq1 = rp; m_full = e.full; m_ovf = e.ovf;
        end
        sb_q.push_back(e);
        @(posedge wclk);
        #1;
        x = sb_q.pop_front();
        checks++;
        if (wptr_gray !== x.gray) begin
            errors++;
            $display("FAIL wptr_gray: got %0h expected %0h at %0t", wptr_gray, x.gray, $time);
        end
        checks++;
        if (wfree !== x.free) begin
            errors++;
            $display("FAIL wfree: got %0d expected %0d at %0t", wfree, x.free, $time);
        end
        checks++;
        if (wfull !== x.full) begin
            errors++;
            $display("FAIL wfull: got %b expected %b at %0t", wfull, x.full, $time);
        end
        checks++;
        if (walmost_full !== x.afull) begin
            errors++;
            $display("FAIL walmost_full: got %b expected %b at %0t", walmost_full, x.afull, $time);
        end
        checks++;
        if (woverflow !== x.ovf) begin
            errors++;
            $display("FAIL woverflow: got %b expected %b at %0t", woverflow, x.ovf, $time);
        end
    endtask

    task automatic test_reset();
        drive_cycle(1'b0, 1'b1, 1'b0, 9'h000);
        drive_cycle(1'b0, 1'b1, 1'b0, 9'h000);
        checks++;
        if (wptr_gray !== 9'h000 || wfree !== 9'd256 || wfull !== 1'b0 || woverflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got gray=%0h free=%0d full=%b ovf=%b expected 0/256/0/0",
                     wptr_gray, wfree, wfull, woverflow);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 256; i++) begin
            drive_cycle(1'b1, 1'b1, 1'b0, 9'h000);
            if (i == 251) begin
                checks++;
                if (walmost_full !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_afull_251: got %b expected 0", walmost_full);
                end
            end
            if (i == 252) begin
                checks++;
                if (walmost_full !== 1'b1 || wfree !== 9'd4) begin
                    errors++;
                    $display("FAIL fill_afull_252: got afull=%b free=%0d expected 1/4", walmost_full, wfree);
                end
            end
        end
        checks++;
        if (wfull !== 1'b1 || wfree !== 9'd0 || wptr_gray !== 9'h180) begin
            errors++;
            $display("FAIL fill_full: got full=%b free=%0d gray=%0h expected 1/0/180", wfull, wfree, wptr_gray);
        end
    endtask

    task automatic test_overflow();
        drive_cycle(1'b1, 1'b1, 1'b0, 9'h000);
        checks++;
        if (wptr_gray !== 9'h180 || woverflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: got gray=%0h ovf=%b expected 180/1", wptr_gray, woverflow);
        end
        drive_cycle(1'b1, 1'b0, 1'b1, 9'h000);
        checks++;
        if (woverflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b expected 0", woverflow);
        end
        drive_cycle(1'b1, 1'b1, 1'b1, 9'h000);
        checks++;
        if (woverflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set_wins: got %b expected 1", woverflow);
        end
        drive_cycle(1'b1, 1'b0, 1'b1, 9'h000);
    endtask

    task automatic test_drain();
        rd_bin = 9'd1;
        for (int e = 1; e <= 3; e++) begin
            drive_cycle(1'b1, 1'b0, 1'b0, b2g(rd_bin));
            if (e < 3) begin
                checks++;
                if (wfull !== 1'b1) begin
                    errors++;
                    $display("FAIL drain_early_edge%0d: got wfull=%b expected 1", e, wfull);
                end
            end
        end
        checks++;
        if (wfull !== 1'b0 || wfree !== 9'd1) begin
            errors++;
            $display("FAIL drain_edge3: got full=%b free=%0d expected 0/1", wfull, wfree);
        end
    endtask

    task automatic test_wrap();
        int            start;
        int            cyc;
        int            dut_wraps;
        int            acc;
        int            w0;
        logic [AW-1:0] prev;
        logic [AW-1:0] occ;
        logic [AW-1:0] occ_dut;
        logic          inc;
        logic          clr;
        start = m_writes; cyc = 0; dut_wraps = 0;
        while ((m_writes - start) < 1000 && cyc < 20000) begin
            occ = m_wbin - rd_bin;
            if (occ != 9'd0 && $urandom_range(0, 99) < 45) rd_bin = rd_bin + 9'd1;
            inc  = ($urandom_range(0, 99) < 55);
            clr  = ($urandom_range(0, 9) == 0);
            prev = wptr_gray;
            w0   = m_writes;
            drive_cycle(1'b1, inc, clr, b2g(rd_bin));
            acc = m_writes - w0;
            cyc++;
            checks++;
            if ($countones(prev ^ wptr_gray) != acc) begin
                errors++;
                $display("FAIL gray_step: got %0h->%0h expected %0d bit change", prev, wptr_gray, acc);
            end
            if (g2b(wptr_gray) < g2b(prev)) dut_wraps++;
            occ_dut = g2b(wptr_gray) - rd_bin;
            checks++;
            if (occ_dut > 9'd256 || wfree > (9'd256 - occ_dut)) begin
                errors++;
                $display("FAIL occupancy: got occ=%0d free=%0d expected occ<=256 free<=%0d",
                         occ_dut, wfree, 9'd256 - occ_dut);
            end
        end
        checks++;
        if ((m_writes - start) < 1000) begin
            errors++;
            $display("FAIL wrap_timeout: got %0d writes expected 1000", m_writes - start);
        end
        checks++;
        if (dut_wraps < 1) begin
            errors++;
            $display("FAIL wrap_count: got %0d expected >=1", dut_wraps);
        end
    endtask

    task automatic test_mid_reset();
        int start;
        int cyc;
        start = m_writes; cyc = 0;
        while ((m_writes - start) < 100 && cyc < 1000) begin
            if (m_wbin != rd_bin) rd_bin = rd_bin + 9'd1;
            drive_cycle(1'b1, 1'b1, 1'b0, b2g(rd_bin));
            cyc++;
        end
        checks++;
        if ((m_writes - start) < 100) begin
            errors++;
            $display("FAIL midrst_timeout: got %0d writes expected 100", m_writes - start);
        end
        rd_bin = '0;
        drive_cycle(1'b0, 1'b1, 1'b0, 9'h000);
        checks++;
        if (wptr_gray !== 9'h000 || wfree !== 9'd256 || wfull !== 1'b0 ||
            walmost_full !== 1'b0 || woverflow !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state: got gray=%0h free=%0d full=%b afull=%b ovf=%b expected 0/256/0/0/0",
                     wptr_gray, wfree, wfull, walmost_full, woverflow);
        end
        wrst_n = 1'b1; winc = 1'b1; ovf_clr = 1'b0; rptr_gray = 9'h000;
        #1;
        checks++;
        if (wen !== 1'b1 || waddr !== 8'h00) begin
            errors++;
            $display("FAIL midrst_first_write: got wen=%b waddr=%0h expected 1/0", wen, waddr);
        end
        drive_cycle(1'b1, 1'b1, 1'b0, 9'h000);
        checks++;
        if (wptr_gray !== 9'h001) begin
            errors++;
            $display("FAIL midrst_ptr: got %0h expected 1", wptr_gray);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_wrap();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
